// File: rtl/macpu_fetch_pkg.sv
// rtl/macpu_fetch_pkg.sv - shared types and defaults for the instruction fetch stage
package macpu_fetch_pkg;

   // Default geometry; the address width has to track the PC width.
   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam int DEPTH_DEF  = 4;

   // Fetch controller states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

   // Each queue entry carries the fetch address above the instruction word.
   function automatic int entry_width(input int addr_w, input int data_w);
      return addr_w + data_w;
   endfunction

   localparam int ENTRY_W_DEF = ADDR_W_DEF + DATA_W_DEF;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO with flush, occupancy count and registered head
module fetch_queue
   import macpu_fetch_pkg::*;
#(
   parameter  int WIDTH = ENTRY_W_DEF,
   parameter  int DEPTH = DEPTH_DEF,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             flush,
   input  logic             enq,
   input  logic [WIDTH-1:0] enq_data,
   input  logic             deq,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_n;
   logic [CNT_W-1:0] count_n;
   logic [WIDTH-1:0] head_n;

   // Next read pointer, occupancy and head word; a word written into the slot
   // that becomes the head this cycle is bypassed straight into the head register.
   always_comb begin
      rd_ptr_n = rd_ptr + PTR_W'(deq);
      count_n  = count + CNT_W'(enq) - CNT_W'(deq);
      head_n   = head;
      if (count_n != '0) begin
         if (enq && (wr_ptr == rd_ptr_n)) begin
            head_n = enq_data;
         end else begin
            head_n = mem[rd_ptr_n];
         end
      end
   end

   // Entry storage; only the write pointer slot is ever touched.
   always_ff @(posedge clk) begin
      if (enq && !flush) begin
         mem[wr_ptr] <= enq_data;
      end
   end

   // Pointers, count and head register; flush empties the queue at the edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(enq);
         rd_ptr <= rd_ptr_n;
         count  <= count_n;
         head   <= head_n;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage between program counter and decoder
module instruction_fetch
   import macpu_fetch_pkg::*;
#(
   parameter  int ADDR_W = ADDR_W_DEF,
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [ADDR_W-1:0] i_pc_address,
   output logic              o_pc_address_en,
   output logic              o_pc_lock,
   input  logic              i_flush,
   output logic              o_mem_req,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic              i_mem_ack,
   input  logic [DATA_W-1:0] i_mem_data,
   output logic              o_instr_valid,
   output logic [DATA_W-1:0] o_instr,
   output logic [ADDR_W-1:0] o_instr_addr,
   input  logic              i_instr_ready,
   output logic [CNT_W-1:0]  o_queue_count
);

   localparam int              ENTRY_W = entry_width(ADDR_W, DATA_W);
   localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);

   fetch_state_t       state;
   fetch_state_t       state_n;
   logic [ADDR_W-1:0]  drain_addr;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_after_deq;
   logic [CNT_W-1:0]   count_after_both;
   logic [ENTRY_W-1:0] head;
   logic               deq;
   logic               enq;

   // The head is offered only when present and not being thrown away by a redirect.
   assign o_instr_valid    = (count != '0) && !i_flush;
   assign deq              = o_instr_valid && i_instr_ready;
   assign count_after_deq  = count - CNT_W'(deq);
   assign count_after_both = count + CNT_W'(1) - CNT_W'(deq);

   assign o_instr_addr  = head[ENTRY_W-1 -: ADDR_W];
   assign o_instr       = head[DATA_W-1:0];
   assign o_queue_count = count;

   // The PC address path is disabled while draining a stale request and in reset.
   assign o_pc_address_en = n_rst && (state != ST_DRAIN);

   // Next state and handshake outputs; the PC is released only on an accepted ack.
   always_comb begin
      state_n    = state;
      o_mem_req  = 1'b0;
      o_mem_addr = i_pc_address;
      o_pc_lock  = 1'b1;
      enq        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!i_flush && (count_after_deq < FULL)) begin
               state_n = ST_REQ;
            end
         end
         ST_REQ: begin
            o_mem_req = 1'b1;
            if (i_flush) begin
               state_n = i_mem_ack ? ST_IDLE : ST_DRAIN;
            end else if (i_mem_ack) begin
               enq       = 1'b1;
               o_pc_lock = 1'b0;
               if (!(count_after_both < FULL)) begin
                  state_n = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            o_mem_req  = 1'b1;
            o_mem_addr = drain_addr;
            if (i_mem_ack) begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Freeze the outstanding address when a redirect abandons a request mid-flight,
   // since the PC moves to the new target at the same edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         drain_addr <= '0;
      end else if ((state == ST_REQ) && i_flush && !i_mem_ack) begin
         drain_addr <= i_pc_address;
      end
   end

   fetch_queue #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk      (clk),
      .n_rst    (n_rst),
      .flush    (i_flush),
      .enq      (enq),
      .enq_data ({i_pc_address, i_mem_data}),
      .deq      (deq),
      .count    (count),
      .head     (head)
   );

endmodule
